// File: rtl/mlp_error_batch.sv
// Per-class error vector, argmax prediction and per-batch error statistics.
// Defining MLP_ERR_SQERR_EN adds the sq_err_acc squared-error accumulator port.
//
// state | meaning
// IDLE  | samples are processed, batch statistics held
// RUN   | accepted samples are counted and accumulated
// DONE  | batch_done for one cycle, then IDLE
module mlp_error_batch #(
    parameter int W     = 8,
    parameter int FRAC  = 6,
    parameter int N_CLS = 2,
    parameter int CLS_W = 1,
    parameter int MODE  = 0,
    parameter int CNT_W = 8,
    parameter int ACC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_CLS*W-1:0] y_score,
    input  logic [CLS_W-1:0]   cls_idx,
    output logic               err_valid,
    input  logic               err_ready,
    output logic [N_CLS*W-1:0] err_out,
    output logic [CLS_W-1:0]   pred_idx,
    output logic               correct,
    input  logic               batch_start,
    input  logic [CNT_W-1:0]   batch_len,
    output logic               batch_busy,
    output logic               batch_done,
    output logic [ACC_W-1:0]   abs_err_acc,
`ifdef MLP_ERR_SQERR_EN
    output logic [ACC_W-1:0]   sq_err_acc,
`endif
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam logic signed [W-1:0] ONE = W'(1 << FRAC);
    localparam int SUM_W = W + $clog2(N_CLS) + 1;
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'({ACC_W{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic [N_CLS*W-1:0] err_c;
    logic [CLS_W-1:0]   pred_c;
    logic               correct_c;
    logic [SUM_W-1:0]   abs_sum_c;
    logic [CNT_W-1:0]   cnt, len, cnt_inc, cnt_base;
    logic               clr, add;
    logic [ACC_W-1:0]   abs_base, abs_upd;
    logic [EXT_W-1:0]   abs_wide;
    logic [CNT_W-1:0]   miss_base, miss_upd;
`ifdef MLP_ERR_SQERR_EN
    logic [SUM_W-1:0]   sq_sum_c;
    logic [ACC_W-1:0]   sq_base, sq_upd;
    logic [EXT_W-1:0]   sq_wide;
`endif

    assign in_ready   = !err_valid || err_ready;
    assign accept     = in_valid && in_ready;
    assign batch_busy = (state == RUN);
    assign batch_done = (state == DONE);

    // Quantise, subtract from one-hot target, and track the argmax (ties keep lowest index).
    always_comb begin
        logic signed [W-1:0]   s, q, t, e, best;
        logic signed [2*W-1:0] p;
        s = '0;
        q = '0;
        t = '0;
        e = '0;
        p = '0;
        best = $signed(y_score[W-1:0]);
        err_c = '0;
        pred_c = '0;
        abs_sum_c = '0;
`ifdef MLP_ERR_SQERR_EN
        sq_sum_c = '0;
`endif
        for (int k = 0; k < N_CLS; k++) begin
            s = $signed(y_score[k*W +: W]);
            if (MODE == 0)
                q = (s > 0) ? ONE : '0;
            else if (s < 0)
                q = '0;
            else if (s > ONE)
                q = ONE;
            else
                q = s;
            t = (int'(cls_idx) == k) ? ONE : '0;
            e = t - q;
            err_c[k*W +: W] = e;
            abs_sum_c = abs_sum_c + SUM_W'((e < 0) ? -e : e);
            p = (2*W)'(e) * (2*W)'(e);
`ifdef MLP_ERR_SQERR_EN
            sq_sum_c = sq_sum_c + SUM_W'(p >> FRAC);
`endif
            if (k > 0 && s > best) begin
                best = s;
                pred_c = CLS_W'(k);
            end
        end
    end

    assign correct_c = (pred_c == cls_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_out   <= '0;
            pred_idx  <= '0;
            correct   <= 1'b0;
        end else if (accept) begin
            err_valid <= 1'b1;
            err_out   <= err_c;
            pred_idx  <= pred_c;
            correct   <= correct_c;
        end else if (err_ready) begin
            err_valid <= 1'b0;
        end
    end

    // A batch_start overrides the current state; a same-cycle accept becomes sample 1.
    always_comb begin
        state_nxt = state;
        clr = 1'b0;
        add = 1'b0;
        cnt_inc = cnt + 1'b1;
        case (state)
            IDLE: state_nxt = IDLE;
            RUN: begin
                if (accept) begin
                    add = 1'b1;
                    if (cnt_inc == len)
                        state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (batch_start) begin
            clr = 1'b1;
            add = 1'b0;
            if (batch_len == '0) begin
                state_nxt = DONE;
            end else if (accept) begin
                add = 1'b1;
                state_nxt = (batch_len == CNT_W'(1)) ? DONE : RUN;
            end else begin
                state_nxt = RUN;
            end
        end
    end

    always_comb begin
        cnt_base  = clr ? '0 : cnt;
        abs_base  = clr ? '0 : abs_err_acc;
        miss_base = clr ? '0 : miss_cnt;
        abs_wide  = EXT_W'(abs_base) + EXT_W'(abs_sum_c);
        abs_upd   = (abs_wide > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(abs_wide);
        if (correct_c || miss_base == '1)
            miss_upd = miss_base;
        else
            miss_upd = miss_base + 1'b1;
`ifdef MLP_ERR_SQERR_EN
        sq_base = clr ? '0 : sq_err_acc;
        sq_wide = EXT_W'(sq_base) + EXT_W'(sq_sum_c);
        sq_upd  = (sq_wide > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(sq_wide);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            abs_err_acc <= '0;
            miss_cnt    <= '0;
`ifdef MLP_ERR_SQERR_EN
            sq_err_acc  <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (batch_start)
                len <= batch_len;
            if (clr || add) begin
                cnt         <= add ? cnt_base + 1'b1 : cnt_base;
                abs_err_acc <= add ? abs_upd : abs_base;
                miss_cnt    <= add ? miss_upd : miss_base;
`ifdef MLP_ERR_SQERR_EN
                sq_err_acc  <= add ? sq_upd : sq_base;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mlp_error_batch.sv
// Directed bench for mlp_error_batch: MODE 0 and MODE 1 instances share stimulus.
module tb_mlp_error_batch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] y_score = '0;
    logic        cls_idx = 1'b0;
    logic        err_ready = 1'b1;
    logic        batch_start = 1'b0;
    logic [7:0]  batch_len = '0;

    logic        in_ready0, err_valid0, correct0, busy0, done0, pred0;
    logic [15:0] err0, abs0;
    logic [7:0]  miss0;
    logic        in_ready1, err_valid1, correct1, busy1, done1, pred1;
    logic [15:0] err1, abs1;
    logic [7:0]  miss1;
`ifdef MLP_ERR_SQERR_EN
    logic [15:0] sq0, sq1;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mlp_error_batch #(.MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .y_score(y_score), .cls_idx(cls_idx), .err_valid(err_valid0), .err_ready(err_ready),
        .err_out(err0), .pred_idx(pred0), .correct(correct0), .batch_start(batch_start),
        .batch_len(batch_len), .batch_busy(busy0), .batch_done(done0), .abs_err_acc(abs0),
`ifdef MLP_ERR_SQERR_EN
        .sq_err_acc(sq0),
`endif
        .miss_cnt(miss0)
    );

    mlp_error_batch #(.MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .y_score(y_score), .cls_idx(cls_idx), .err_valid(err_valid1), .err_ready(err_ready),
        .err_out(err1), .pred_idx(pred1), .correct(correct1), .batch_start(batch_start),
        .batch_len(batch_len), .batch_busy(busy1), .batch_done(done1), .abs_err_acc(abs1),
`ifdef MLP_ERR_SQERR_EN
        .sq_err_acc(sq1),
`endif
        .miss_cnt(miss1)
    );

    typedef struct {
        logic        mode;
        logic [7:0]  s1, s0;
        logic        cls;
        logic [15:0] err;
        logic        pred, corr;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input int mode, input int s1, input int s0, input int cls,
                                input int e1, input int e0, input int pred, input int corr);
        vec_t v;
        v.mode = 1'(mode);
        v.s1   = 8'(s1);
        v.s0   = 8'(s0);
        v.cls  = 1'(cls);
        v.err  = {8'(e1), 8'(e0)};
        v.pred = 1'(pred);
        v.corr = 1'(corr);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int s1, input int s0, input int cls);
        y_score  = {8'(s1), 8'(s0)};
        cls_idx  = 1'(cls);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic start(input int n);
        batch_start = 1'b1;
        batch_len   = 8'(n);
        @(posedge clk); #1;
        batch_start = 1'b0;
    endtask

    initial begin
        int done_seen;
        //             mode  s1    s0  cls  e1   e0  pred corr
        vecs[0] = mk(0,   -5,   20, 0,    0,   0, 0, 1);
        vecs[1] = mk(0,   -5,   20, 1,   64, -64, 0, 0);
        vecs[2] = mk(0,   20,   20, 1,    0, -64, 0, 0);
        vecs[3] = mk(0,    0,   -3, 1,   64,   0, 1, 1);
        vecs[4] = mk(0, -128, -128, 0,    0,  64, 0, 1);
        vecs[5] = mk(0,  127,    1, 0,  -64,   0, 1, 0);
        vecs[6] = mk(1,  100,   30, 0,  -64,  34, 1, 0);
        vecs[7] = mk(1,  -10,   64, 0,    0,   0, 0, 1);
        vecs[8] = mk(1,   65,   -1, 1,    0,   0, 1, 1);
        vecs[9] = mk(1,   63,   63, 1,    1, -63, 0, 0);

        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_err_valid", 32'(err_valid0), 0);
        chk("rst_err_out", 32'(err0), 0);
        chk("rst_pred", 32'(pred0), 0);
        chk("rst_correct", 32'(correct0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_abs", 32'(abs0), 0);
        chk("rst_miss", 32'(miss0), 0);
        chk("rst_in_ready", 32'(in_ready0), 1);

        for (int i = 0; i < 10; i++) begin
            send(int'($signed(vecs[i].s1)), int'($signed(vecs[i].s0)), int'(vecs[i].cls));
            if (vecs[i].mode == 1'b0) begin
                chk($sformatf("v%0d_valid", i), 32'(err_valid0), 1);
                chk($sformatf("v%0d_err", i), 32'(err0), 32'(vecs[i].err));
                chk($sformatf("v%0d_pred", i), 32'(pred0), 32'(vecs[i].pred));
                chk($sformatf("v%0d_corr", i), 32'(correct0), 32'(vecs[i].corr));
            end else begin
                chk($sformatf("v%0d_valid", i), 32'(err_valid1), 1);
                chk($sformatf("v%0d_err", i), 32'(err1), 32'(vecs[i].err));
                chk($sformatf("v%0d_pred", i), 32'(pred1), 32'(vecs[i].pred));
                chk($sformatf("v%0d_corr", i), 32'(correct1), 32'(vecs[i].corr));
            end
        end
        chk("idle_abs_hold", 32'(abs0), 0);
        chk("idle_miss_hold", 32'(miss0), 0);
        @(posedge clk); #1;
        chk("valid_drops", 32'(err_valid0), 0);

        // Backpressure inside a 2-sample batch: stalls must not advance the count.
        start(2);
        chk("bp_busy", 32'(busy0), 1);
        send(-5, 20, 0);
        err_ready = 1'b0;
        y_score   = {8'(-5), 8'(20)};
        cls_idx   = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk("bp_in_ready_low", 32'(in_ready0), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_err%0d", c), 32'(err0), 0);
            chk($sformatf("bp_hold_valid%0d", c), 32'(err_valid0), 1);
            chk($sformatf("bp_no_done%0d", c), 32'(done0), 0);
            chk($sformatf("bp_busy%0d", c), 32'(busy0), 1);
        end
        err_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready0), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_err", 32'(err0), 32'h40C0);
        chk("bp_done", 32'(done0), 1);
        chk("bp_abs", 32'(abs0), 128);
        chk("bp_miss", 32'(miss0), 1);

        // Three-sample batch: 0 + 128 + 128 abs error, two misses.
        start(3);
        chk("b3_cleared_abs", 32'(abs0), 0);
        chk("b3_cleared_miss", 32'(miss0), 0);
        send(-5, 20, 0);
        send(-5, 20, 1);
        chk("b3_no_early_done", 32'(done0), 0);
        send(-5, 20, 1);
        chk("b3_done", 32'(done0), 1);
        chk("b3_abs", 32'(abs0), 256);
        chk("b3_miss", 32'(miss0), 2);
`ifdef MLP_ERR_SQERR_EN
        chk("b3_sq", 32'(sq0), 256);
`endif
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done0) done_seen++;
        end
        chk("b3_single_pulse", 32'(done_seen), 0);
        chk("b3_abs_hold", 32'(abs0), 256);
        chk("b3_miss_hold", 32'(miss0), 2);
        chk("b3_idle", 32'(busy0), 0);

        // Zero-length batch goes straight to DONE with cleared statistics.
        start(0);
        chk("len0_done", 32'(done0), 1);
        chk("len0_abs", 32'(abs0), 0);
        chk("len0_miss", 32'(miss0), 0);
`ifdef MLP_ERR_SQERR_EN
        chk("len0_sq", 32'(sq0), 0);
`endif
        @(posedge clk); #1;
        chk("len0_done_off", 32'(done0), 0);

        // Restart after one sample aborts silently.
        start(3);
        send(-5, 20, 1);
        chk("abort_pre_miss", 32'(miss0), 1);
        start(3);
        chk("abort_abs", 32'(abs0), 0);
        chk("abort_miss", 32'(miss0), 0);
        chk("abort_busy", 32'(busy0), 1);
        chk("abort_no_done", 32'(done0), 0);

        // Restart in the same cycle as an accept: that sample is sample 1 of 2.
        batch_start = 1'b1;
        batch_len   = 8'd2;
        y_score     = {8'(-5), 8'(20)};
        cls_idx     = 1'b1;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        batch_start = 1'b0;
        in_valid    = 1'b0;
        chk("same_abs", 32'(abs0), 128);
        chk("same_miss", 32'(miss0), 1);
        chk("same_busy", 32'(busy0), 1);
        send(-5, 20, 0);
        chk("same_done", 32'(done0), 1);
        chk("same_abs_end", 32'(abs0), 128);
        chk("same_miss_end", 32'(miss0), 1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a batch.
        start(3);
        send(-5, 20, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(err_valid0), 0);
        chk("arst_err", 32'(err0), 0);
        chk("arst_busy", 32'(busy0), 0);
        chk("arst_abs", 32'(abs0), 0);
        chk("arst_miss", 32'(miss0), 0);
        chk("arst_done", 32'(done0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done0) done_seen++;
        end
        chk("arst_no_done", 32'(done_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mlp_error_batch.md
Name: mlp_error_batch

Overview:
Parametrised successor to the single-bit O/X error stage. It takes N_CLS signed class scores per sample and computes a per-class error vector (target minus quantised output) in Q(FRAC) format. It also reports argmax prediction and correctness. Per-batch statistics (sum of absolute error, miss count) are accumulated for the training controller. It sits between the MLP output layer and the weight-update/backprop block, with valid/ready on both sides.

Parameters:
W, 8, score/error word width (signed)
FRAC, 6, fractional bits; ONE = 1<<FRAC; legal only if FRAC <= W-2
N_CLS, 2, number of output classes (>=2)
CLS_W, 1, width of class index; must satisfy 2^CLS_W >= N_CLS
MODE, 0, 0 = hard output (score>0 -> ONE, else 0); 1 = soft output (score clamped to [0, ONE])
CNT_W, 8, batch length / counter width
ACC_W, 16, absolute-error accumulator width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
y_score  in  N_CLS*W  signed scores; class k at bits [k*W +: W]
cls_idx  in  CLS_W  correct class of the sample
err_valid  out  1  error vector valid
err_ready  in  1  downstream accepts error vector
err_out  out  N_CLS*W  signed per-class error, class k at [k*W +: W]
pred_idx  out  CLS_W  argmax class of accepted sample
correct  out  1  pred_idx == cls_idx
batch_start  in  1  one-cycle pulse: start a new batch
batch_len  in  CNT_W  samples in batch, sampled on batch_start
batch_busy  out  1  FSM in RUN
batch_done  out  1  one-cycle pulse at batch end
abs_err_acc  out  ACC_W  sum of |err_out[k]| over all classes and batch samples, unsigned, saturating
miss_cnt  out  CNT_W  samples with correct==0 in batch

Behaviour:
- Reset (async, rst_n=0): err_valid=0, err_out=0, pred_idx=0, correct=0, batch_busy=0, batch_done=0, abs_err_acc=0, miss_cnt=0, FSM=IDLE, sample counter=0.
- Handshake: in_ready = !err_valid || err_ready (combinational). Accept when in_valid && in_ready. Output register loads on accept, so latency is 1 cycle. err_valid is set on accept and cleared when err_ready is high with no new accept. Output holds stable while err_valid && !err_ready.
- Target: target_k = ONE if k==cls_idx, else 0. cls_idx >= N_CLS gives an all-zero target.
- Output quantisation:
  - MODE 0: q_k = (y_score_k > 0) ? ONE : 0.
  - MODE 1: q_k = 0 if y_score_k<0, ONE if y_score_k>ONE, else y_score_k.
- Error: err_k = target_k - q_k, range [-ONE, ONE]; never overflows W.
- pred_idx: index of the maximum signed score; ties go to the lowest index. correct = (pred_idx==cls_idx).
- FSM states:
  - IDLE: samples are processed normally but not accumulated. batch_start -> latch batch_len, clear abs_err_acc, miss_cnt and counter; go to RUN. If batch_len==0, go to DONE instead.
  - RUN: on each accept, counter+1, abs_err_acc += sum_k |err_k| (saturate at 2^ACC_W-1), miss_cnt += !correct (saturate). The accept that makes counter==len -> DONE.
  - DONE: batch_done=1 for exactly this cycle; go to IDLE. Accumulators hold until the next batch_start.
- batch_start during RUN or DONE restarts: clears accumulators, reloads len, enters RUN; batch_done is not pulsed for the aborted batch.
- batch_start in the same cycle as an accept: the restart wins, and the accepted sample counts as sample 1 of the new batch.
- Stalls (err_ready=0) do not affect the counter; only accepts count.
- Reset mid-batch: everything returns to reset values immediately; no batch_done.

Optional Feature:
MLP_ERR_SQERR_EN:
- When defined: adds output port sq_err_acc (ACC_W, unsigned). In RUN, each accept adds sum_k (err_k*err_k)>>FRAC, saturating. It is cleared and held alongside abs_err_acc.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults, MODE0, reset released, y_score={k1:-5,k0:+20}, cls_idx=0, err_ready=1 -> next cycle err_valid=1, err_out={k1:0,k0:0}, pred_idx=0, correct=1.
2. Same scores with cls_idx=1 -> err_out={k1:+64,k0:-64}, pred_idx=0, correct=0.
3. MODE1, y_score={k1:100,k0:30}, cls_idx=0 -> q={64,30}, err_out={k1:-64,k0:+34}, pred_idx=1.
4. Backpressure: err_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, err_out stable, counter unchanged; on err_ready=1 the next sample is accepted.
5. batch_start with batch_len=3, three samples as in tests 1, 2, 2 -> batch_done pulses once, the cycle after the third accept; abs_err_acc=256, miss_cnt=2; values hold until the next batch_start. With MLP_ERR_SQERR_EN: sq_err_acc=256.
6. Edge cases:
   - batch_len=0 -> DONE the next cycle, accumulators 0.
   - batch_start after 1 of 3 samples -> counters cleared, no batch_done.
   - rst_n low mid-RUN -> all outputs 0 asynchronously.
